// File: rtl/decode_ctrl.sv
// decode_ctrl -- instruction decode and sequencing for the 4-bit nibble CPU.
//
// Splits the fetched byte into opcode/operand, paces the front end
// (pc_en / pc_load / fetch_en) and issues one-cycle execute controls to
// the accumulator/ALU/IO datapath. Keeps the C/Z flag register used by
// the conditional jumps.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : opcode E traps (sticky trap=1) and halts
//   undefined : opcode E is a NOP, trap tied low
//
// Parameter START_ON_RESET : 0 wait for go in IDLE, 1 start fetching at once.
//
// Ports
//   clk, reset (async, active low), go
//   instr[7:0]          fetch register output
//   alu_c, alu_z        ALU flags of the current operation
//   pc_en, pc_load, pc_d[11:0], fetch_en   front-end control
//   oprnd[3:0]          latched operand nibble
//   alu_sel[2:0], acc_en, bus_oe, in_en, out_en   datapath controls
//   c_flag, z_flag      flag register
//   halted, trap        status
module decode_ctrl #(
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [7:0]  instr,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic        pc_en,
  output logic        pc_load,
  output logic [11:0] pc_d,
  output logic        fetch_en,
  output logic [3:0]  oprnd,
  output logic [2:0]  alu_sel,
  output logic        acc_en,
  output logic        bus_oe,
  output logic        in_en,
  output logic        out_en,
  output logic        c_flag,
  output logic        z_flag,
  output logic        halted,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic [3:0] op;
  logic       taken;
  logic       flag_op;
  logic       trap_op;

  assign op    = ir[7:4];
  assign oprnd = ir[3:0];

  // Conditional jumps look only at the registered flags.
  always_comb begin
    taken = 1'b0;
    case (op)
      4'h9:    taken = 1'b1;
      4'hA:    taken = c_flag;
      4'hB:    taken = z_flag;
      4'hC:    taken = ~c_flag;
      4'hD:    taken = ~z_flag;
      default: taken = 1'b0;
    endcase
  end

  assign flag_op = ((op >= 4'h2) && (op <= 4'h5)) || (op == 4'h8);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign trap_op = (op == 4'hE);
`else
  assign trap_op = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state. DECODE looks at instr directly because IR is only
  // loaded on that same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START_ON_RESET || go) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = ((instr[7:4] >= 4'h9) && (instr[7:4] <= 4'hD))
                            ? S_FETCH2 : S_EXEC;
      S_FETCH2: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = ((op == 4'hF) || trap_op) ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // IR and flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir     <= 8'h00;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (state == S_DECODE) ir <= instr;
      if ((state == S_EXEC) && flag_op) begin
        c_flag <= alu_c;
        z_flag <= alu_z;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          trap_q <= 1'b0;
    else if ((state == S_EXEC) && trap_op) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // Moore outputs; pc_d is the only one that reads instr (low address byte).
  always_comb begin
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    pc_d     = 12'h000;
    fetch_en = 1'b0;
    alu_sel  = 3'b000;
    acc_en   = 1'b0;
    bus_oe   = 1'b0;
    in_en    = 1'b0;
    out_en   = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH, S_FETCH2: begin
        fetch_en = 1'b1;
        pc_en    = 1'b1;
      end
      S_EXEC: begin
        case (op)
          4'h1: begin bus_oe = 1'b1; acc_en = 1'b1; end
          4'h2, 4'h3, 4'h4, 4'h5: begin
            bus_oe  = 1'b1;
            acc_en  = 1'b1;
            alu_sel = op[2:0] - 3'd1;
          end
          4'h6: out_en = 1'b1;
          4'h7: begin in_en = 1'b1; acc_en = 1'b1; end
          4'h8: begin bus_oe = 1'b1; alu_sel = 3'b010; end
          4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
            pc_load = taken;
            pc_d    = taken ? {ir[3:0], instr} : 12'h000;
          end
          default: ;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decode_ctrl.sv
module tb_decode_ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  instr;
  logic        alu_c = 1'b0, alu_z = 1'b0;
  logic        pc_en, pc_load, fetch_en, acc_en, bus_oe, in_en, out_en;
  logic        c_flag, z_flag, halted, trap;
  logic [11:0] pc_d;
  logic [3:0]  oprnd;
  logic [2:0]  alu_sel;

  decode_ctrl dut (
    .clk(clk), .reset(reset), .go(go), .instr(instr),
    .alu_c(alu_c), .alu_z(alu_z),
    .pc_en(pc_en), .pc_load(pc_load), .pc_d(pc_d), .fetch_en(fetch_en),
    .oprnd(oprnd), .alu_sel(alu_sel), .acc_en(acc_en), .bus_oe(bus_oe),
    .in_en(in_en), .out_en(out_en), .c_flag(c_flag), .z_flag(z_flag),
    .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  // Environment: program ROM, PC and fetch register, driven by the model.
  logic [7:0]  rom [0:4095];
  logic [11:0] pc;
  logic [7:0]  fr;
  assign instr = fr;

  // Architectural model state
  logic [7:0] ir_m;
  logic       c_m, z_m, hlt_m, tr_m;

  int checks = 0;
  int failures = 0;

  logic force_alu = 1'b0;
  logic fc, fz, lc, lz;

  // Captured DUT outputs from the latest sampled cycle
  logic [2:0]  cap_sel;
  logic [3:0]  cap_opr;
  logic [11:0] cap_pcd;
  logic        cap_acc, cap_boe, cap_ld, cap_halted, cap_trap;

  wire [29:0] dut_v = {pc_en, pc_load, pc_d, fetch_en, oprnd, alu_sel, acc_en,
                       bus_oe, in_en, out_en, c_flag, z_flag, halted, trap};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] pk(input logic pe, input logic pl, input logic [11:0] pd,
                                     input logic fe, input logic [2:0] sel, input logic ae,
                                     input logic boe, input logic ie, input logic oe,
                                     input logic h);
    return {pe, pl, pd, fe, ir_m[3:0], sel, ae, boe, ie, oe, c_m, z_m, h, tr_m};
  endfunction

  // One clock cycle: drive inputs, compare outputs at negedge, step past posedge.
  task automatic tick(input string name, input logic [29:0] exp, input logic g);
    go = g;
    if (force_alu) begin alu_c = fc; alu_z = fz; end
    else begin alu_c = 1'($urandom_range(0, 1)); alu_z = 1'($urandom_range(0, 1)); end
    lc = alu_c; lz = alu_z;
    @(negedge clk);
    chk(name, {2'b00, dut_v}, {2'b00, exp});
    cap_sel = alu_sel; cap_opr = oprnd; cap_pcd = pc_d; cap_acc = acc_en;
    cap_boe = bus_oe; cap_ld = pc_load; cap_halted = halted; cap_trap = trap;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction at the architectural level, checking each cycle.
  task automatic exec_instr(input bit abort, output int ncyc);
    logic [3:0]  op;
    logic [2:0]  sel;
    logic        ae, boe, ie, oe, ld, fl, hn;
    logic [11:0] tgt;
    ncyc = 0;
    tick("fetch", pk(1, 0, 12'h0, 1, 3'd0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
    ncyc++; fr = rom[pc]; pc = pc + 12'd1;
    tick("decode", pk(0, 0, 12'h0, 0, 3'd0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
    ncyc++; ir_m = fr;
    op = ir_m[7:4];
    if (op >= 4'h9 && op <= 4'hD) begin
      if (abort) begin
        #2 reset = 1'b0;
        #1 chk("reset_mid_fetch2", {2'b00, dut_v}, 32'h0);
        return;
      end
      tick("fetch2", pk(1, 0, 12'h0, 1, 3'd0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
      ncyc++; fr = rom[pc]; pc = pc + 12'd1;
    end
    sel = 3'd0; ae = 0; boe = 0; ie = 0; oe = 0; ld = 0; fl = 0; hn = 0;
    case (op)
      4'h1: begin boe = 1; ae = 1; end
      4'h2, 4'h3, 4'h4, 4'h5: begin boe = 1; ae = 1; fl = 1; sel = op[2:0] - 3'd1; end
      4'h6: oe = 1;
      4'h7: begin ie = 1; ae = 1; end
      4'h8: begin boe = 1; sel = 3'd2; fl = 1; end
      4'h9: ld = 1;
      4'hA: ld = c_m;
      4'hB: ld = z_m;
      4'hC: ld = !c_m;
      4'hD: ld = !z_m;
      4'hE: hn = TRAP;
      4'hF: hn = 1;
      default: ;
    endcase
    tgt = {ir_m[3:0], fr};
    tick("exec", pk(0, ld, ld ? tgt : 12'h0, 0, sel, ae, boe, ie, oe, 0), 1'($urandom_range(0, 1)));
    ncyc++;
    if (ld) pc = tgt;
    if (fl) begin c_m = lc; z_m = lz; end
    if (hn) hlt_m = 1;
    if (op == 4'hE && TRAP) tr_m = 1;
  endtask

  task automatic do_reset();
    reset = 1'b0; go = 1'b1;
    #1 chk("reset_outputs", {2'b00, dut_v}, 32'h0);
    ir_m = 8'h00; c_m = 0; z_m = 0; hlt_m = 0; tr_m = 0; pc = 12'h000; fr = 8'h00;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_hold", {2'b00, dut_v}, 32'h0);
    reset = 1'b1; go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic start();
    tick("idle", pk(0, 0, 12'h0, 0, 3'd0, 0, 0, 0, 0, 0), 1'b0);
    tick("idle", pk(0, 0, 12'h0, 0, 3'd0, 0, 0, 0, 0, 0), 1'b0);
    tick("idle_go", pk(0, 0, 12'h0, 0, 3'd0, 0, 0, 0, 0, 0), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h13; rom[12'h001] = 8'h25;
    rom[12'h002] = 8'h9A; rom[12'h003] = 8'h3C;
    rom[12'hA3C] = 8'h80; rom[12'hA3D] = 8'hA1; rom[12'hA3E] = 8'h00;
    rom[12'h100] = 8'hB2; rom[12'h101] = 8'h00;
    rom[12'h102] = 8'hE0; rom[12'h103] = 8'hF0;

    // Directed program
    do_reset();
    start();
    exec_instr(0, n);
    chk("lit_cycles", n, 3); chk("lit_sel", 32'(cap_sel), 0);
    chk("lit_acc", 32'(cap_acc), 1); chk("lit_oprnd", 32'(cap_opr), 3);
    exec_instr(0, n);
    chk("add_cycles", n, 3); chk("add_sel", 32'(cap_sel), 1); chk("add_boe", 32'(cap_boe), 1);
    exec_instr(0, n);
    chk("jmp_cycles", n, 4); chk("jmp_load", 32'(cap_ld), 1); chk("jmp_pcd", 32'(cap_pcd), 32'hA3C);
    force_alu = 1; fc = 1; fz = 0;
    exec_instr(0, n);
    force_alu = 0;
    chk("cmp_acc", 32'(cap_acc), 0); chk("cmp_sel", 32'(cap_sel), 2);
    exec_instr(0, n);
    chk("jc_load", 32'(cap_ld), 1); chk("jc_pcd", 32'(cap_pcd), 32'h100);
    exec_instr(0, n);
    chk("jz_cycles", n, 4); chk("jz_load", 32'(cap_ld), 0);
    exec_instr(0, n);                       // 0xE0
    if (!hlt_m) exec_instr(0, n);           // 0xF0 when E is a NOP
    for (int i = 0; i < 4; i++)
      tick("halt", pk(0, 0, 12'h0, 0, 3'd0, 0, 0, 0, 0, 1), 1'(i % 2));
    chk("halted", 32'(cap_halted), 1);
    chk("trap_e", 32'(cap_trap), 32'(TRAP));
    do_reset();

    // Reset while fetching a jump's second byte
    rom[12'h000] = 8'h95;
    start();
    exec_instr(1, n);
    do_reset();

    // Randomized program run (no HLT, no trapping opcode)
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF || (TRAP && b[7:4] == 4'hE)) b[7:4] = 4'h0;
      rom[i] = b;
    end
    do_reset();
    start();
    for (int k = 0; k < 400; k++) exec_instr(0, n);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
